// File: rtl/class_rslt_merge.sv
// class_rslt_merge: pairs hash/OFT results into one classification result; CLASS_MERGE_STATS_EN adds result counters
module class_rslt_merge #(
  parameter int VID_WIDTH  = 15,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_LVL  = FIFO_DEPTH - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hsh_rslt_vld,
  input  logic [VID_WIDTH-1:0] hsh_rslt_vid,
  input  logic                 hsh_rslt_hit,
  input  logic                 oft_rslt_vld,
  input  logic [VID_WIDTH-1:0] oft_rslt_vid,
  input  logic                 oft_rslt_hit_miss,
  input  logic                 oft_rslt_err,
  input  logic [VID_WIDTH-1:0] dflt_vid,
  input  logic                 flush,
  output logic                 key_stall,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [VID_WIDTH-1:0] out_vid,
  output logic                 out_hit,
  output logic                 out_err,
  output logic                 ovf_err,
  output logic                 desync_err
`ifdef CLASS_MERGE_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_hit_cnt,
  output logic [31:0]          stat_miss_cnt,
  output logic [31:0]          stat_err_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_LVL);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [VID_WIDTH:0]   hmem [FIFO_DEPTH];
  logic [VID_WIDTH+1:0] omem [FIFO_DEPTH];
  logic [PW-1:0] hwp, hrp, owp, orp, hcnt, ocnt, hcnt_nx, ocnt_nx;
  logic push_h, push_o, h_full, o_full, h_empty, o_empty, pop, h_wr, o_wr, clr, ks_nx;
  logic [VID_WIDTH:0]   h_head;
  logic [VID_WIDTH+1:0] o_head;
  logic [VID_WIDTH-1:0] h_vid, o_vid, m_vid;
  logic h_hit, o_hit, o_err, m_hit, m_err;
  always_comb begin
    push_h   = hsh_rslt_vld && state == RUN;
    push_o   = oft_rslt_vld && state == RUN;
    hcnt     = hwp - hrp;
    ocnt     = owp - orp;
    h_full   = hcnt == DEPTH_P;
    o_full   = ocnt == DEPTH_P;
    h_empty  = hcnt == '0;
    o_empty  = ocnt == '0;
    pop      = (!h_empty || push_h) && (!o_empty || push_o) && (!out_vld || out_rdy) && state == RUN;
    h_wr     = push_h && (!h_full || pop);
    o_wr     = push_o && (!o_full || pop);
    hcnt_nx  = hcnt + PW'(h_wr) - PW'(pop);
    ocnt_nx  = ocnt + PW'(o_wr) - PW'(pop);
    clr      = state == DRAIN && !out_vld;
    state_nx = state == RUN ? (flush ? DRAIN : RUN) : (out_vld ? DRAIN : RUN);
    ks_nx    = state_nx == DRAIN || (!clr && (hcnt_nx >= AFULL_P || ocnt_nx >= AFULL_P));
    h_head   = h_empty ? {hsh_rslt_vid, hsh_rslt_hit} : hmem[hrp[AW-1:0]];
    o_head   = o_empty ? {oft_rslt_vid, oft_rslt_hit_miss, oft_rslt_err} : omem[orp[AW-1:0]];
    h_vid    = h_head[VID_WIDTH:1];
    h_hit    = h_head[0];
    o_vid    = o_head[VID_WIDTH+1:2];
    o_hit    = o_head[1];
    o_err    = o_head[0];
    m_vid    = h_hit ? h_vid : o_hit ? o_vid : dflt_vid;
    m_hit    = h_hit || o_hit;
    m_err    = (h_hit && o_hit) || o_err;
  end
  always_ff @(posedge clk) begin
    if (h_wr) hmem[hwp[AW-1:0]] <= {hsh_rslt_vid, hsh_rslt_hit};
    if (o_wr) omem[owp[AW-1:0]] <= {oft_rslt_vid, oft_rslt_hit_miss, oft_rslt_err};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      hwp        <= '0;
      hrp        <= '0;
      owp        <= '0;
      orp        <= '0;
      key_stall  <= 1'b0;
      ovf_err    <= 1'b0;
      desync_err <= 1'b0;
      out_vld    <= 1'b0;
      out_vid    <= '0;
      out_hit    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      hwp        <= clr ? '0 : hwp + PW'(h_wr);
      hrp        <= clr ? '0 : hrp + PW'(pop);
      owp        <= clr ? '0 : owp + PW'(o_wr);
      orp        <= clr ? '0 : orp + PW'(pop);
      key_stall  <= ks_nx;
      ovf_err    <= ovf_err | (push_h & h_full & !pop) | (push_o & o_full & !pop);
      desync_err <= desync_err | (h_full & o_empty) | (o_full & h_empty);
      if (pop) begin
        out_vld <= 1'b1;
        out_vid <= m_vid;
        out_hit <= m_hit;
        out_err <= m_err;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end
`ifdef CLASS_MERGE_STATS_EN
  logic acc;
  assign acc = out_vld && out_rdy;
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
      stat_err_cnt  <= '0;
    end else begin
      if (acc && out_hit && !(&stat_hit_cnt)) stat_hit_cnt <= stat_hit_cnt + 32'd1;
      if (acc && !out_hit && !(&stat_miss_cnt)) stat_miss_cnt <= stat_miss_cnt + 32'd1;
      if (acc && out_err && !(&stat_err_cnt)) stat_err_cnt <= stat_err_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_class_rslt_merge.sv
// tb_class_rslt_merge: directed-vector bench for class_rslt_merge
module tb_class_rslt_merge;
  localparam int VW = 15;
  logic          clk = 1'b0;
  logic          rst, hsh_rslt_vld, hsh_rslt_hit, oft_rslt_vld, oft_rslt_hit_miss, oft_rslt_err;
  logic          flush, out_rdy, key_stall, out_vld, out_hit, out_err, ovf_err, desync_err;
  logic [VW-1:0] hsh_rslt_vid, oft_rslt_vid, dflt_vid, out_vid;
  int            errs = 0;
  int            checks = 0;
  always #5 clk = ~clk;
  class_rslt_merge #(.VID_WIDTH(VW), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .hsh_rslt_vld(hsh_rslt_vld), .hsh_rslt_vid(hsh_rslt_vid), .hsh_rslt_hit(hsh_rslt_hit),
    .oft_rslt_vld(oft_rslt_vld), .oft_rslt_vid(oft_rslt_vid), .oft_rslt_hit_miss(oft_rslt_hit_miss),
    .oft_rslt_err(oft_rslt_err), .dflt_vid(dflt_vid), .flush(flush), .key_stall(key_stall),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_vid(out_vid), .out_hit(out_hit), .out_err(out_err),
    .ovf_err(ovf_err), .desync_err(desync_err)
  );
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic idle();
    hsh_rslt_vld = 1'b0;
    oft_rslt_vld = 1'b0;
    flush        = 1'b0;
  endtask
  task automatic push_h(input logic [VW-1:0] v, input logic h);
    hsh_rslt_vld = 1'b1;
    hsh_rslt_vid = v;
    hsh_rslt_hit = h;
  endtask
  task automatic push_o(input logic [VW-1:0] v, input logic h, input logic e);
    oft_rslt_vld      = 1'b1;
    oft_rslt_vid      = v;
    oft_rslt_hit_miss = h;
    oft_rslt_err      = e;
  endtask
  task automatic reset_dut();
    idle();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    out_rdy  = 1'b0;
    dflt_vid = 15'h7FFF;
    hsh_rslt_vid = '0; hsh_rslt_hit = 0; oft_rslt_vid = '0; oft_rslt_hit_miss = 0; oft_rslt_err = 0;
    reset_dut();
    checks++;
    if ({out_vld, out_vid, out_hit, out_err, key_stall, ovf_err, desync_err} !== '0) begin
      errs++;
      $display("FAIL reset outputs got vld=%b vid=%h hit=%b err=%b ks=%b ovf=%b ds=%b exp all 0",
               out_vld, out_vid, out_hit, out_err, key_stall, ovf_err, desync_err);
    end
  endtask
  task automatic test_latency();
    reset_dut();
    out_rdy = 1'b1;
    push_h(15'h12, 1'b1);
    cyc(); idle(); cyc(2);
    checks++;
    if (out_vld !== 1'b0) begin errs++; $display("FAIL lat_early got vld=%b exp 0", out_vld); end
    push_o(15'h44, 1'b0, 1'b0);
    cyc(); idle();
    checks++;
    if ({out_vld, out_vid, out_hit, out_err} !== {1'b1, 15'h12, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL lat_result got vld=%b vid=%h hit=%b err=%b exp 1 0012 1 0", out_vld, out_vid, out_hit, out_err);
    end
    cyc();
    checks++;
    if (out_vld !== 1'b0) begin errs++; $display("FAIL lat_accept got vld=%b exp 0", out_vld); end
  endtask
  task automatic test_resolve();
    reset_dut();
    out_rdy = 1'b1;
    push_h(15'h11, 1'b0); push_o(15'h22, 1'b0, 1'b0);
    cyc(); idle();
    checks++;
    if ({out_vld, out_vid, out_hit, out_err} !== {1'b1, 15'h7FFF, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL miss got vld=%b vid=%h hit=%b err=%b exp 1 7fff 0 0", out_vld, out_vid, out_hit, out_err);
    end
    cyc();
    push_h(15'h11, 1'b0); push_o(15'h22, 1'b0, 1'b1);
    cyc(); idle();
    checks++;
    if ({out_vld, out_vid, out_hit, out_err} !== {1'b1, 15'h7FFF, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL miss_err got vld=%b vid=%h hit=%b err=%b exp 1 7fff 0 1", out_vld, out_vid, out_hit, out_err);
    end
    cyc();
    push_h(15'h5, 1'b1); push_o(15'h9, 1'b1, 1'b0);
    cyc(); idle();
    checks++;
    if ({out_vld, out_vid, out_hit, out_err} !== {1'b1, 15'h5, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL both_hit got vld=%b vid=%h hit=%b err=%b exp 1 0005 1 1", out_vld, out_vid, out_hit, out_err);
    end
    cyc();
    push_h(15'h5, 1'b0); push_o(15'h9, 1'b1, 1'b0);
    cyc(); idle();
    checks++;
    if ({out_vld, out_vid, out_hit, out_err} !== {1'b1, 15'h9, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL oft_hit got vld=%b vid=%h hit=%b err=%b exp 1 0009 1 0", out_vld, out_vid, out_hit, out_err);
    end
    cyc();
  endtask
  task automatic test_full();
    reset_dut();
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_h(VW'(i + 1), 1'b1);
      cyc();
      checks++;
      if (key_stall !== (i >= 5)) begin
        errs++;
        $display("FAIL full_stall push %0d got ks=%b exp %b", i + 1, key_stall, i >= 5);
      end
    end
    checks++;
    if (ovf_err !== 1'b0) begin errs++; $display("FAIL full_no_ovf got ovf=%b exp 0", ovf_err); end
    push_h(15'h9, 1'b1);
    cyc(); idle();
    checks++;
    if ({ovf_err, desync_err} !== 2'b11) begin
      errs++;
      $display("FAIL full_flags got ovf=%b ds=%b exp 1 1", ovf_err, desync_err);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_o(VW'(15'h100 + i), 1'b0, 1'b0);
      cyc();
      checks++;
      if ({out_vld, out_vid, out_hit, out_err} !== {1'b1, VW'(i + 1), 1'b1, 1'b0}) begin
        errs++;
        $display("FAIL drain_out %0d got vld=%b vid=%h hit=%b err=%b exp 1 %h 1 0",
                 i, out_vld, out_vid, out_hit, out_err, VW'(i + 1));
      end
    end
    idle();
    cyc();
    checks++;
    if ({out_vld, key_stall, ovf_err} !== 3'b001) begin
      errs++;
      $display("FAIL full_end got vld=%b ks=%b ovf=%b exp 0 0 1", out_vld, key_stall, ovf_err);
    end
  endtask
  task automatic test_back_to_back();
    reset_dut();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_h(VW'(15'h21 + i), 1'b1); push_o(15'h0, 1'b0, 1'b0);
      cyc();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_vld, out_vid, out_hit} !== {1'b1, 15'h21, 1'b1}) begin
        errs++;
        $display("FAIL hold %0d got vld=%b vid=%h hit=%b exp 1 0021 1", i, out_vld, out_vid, out_hit);
      end
      cyc();
    end
    out_rdy = 1'b1;
    for (int i = 1; i < 3; i++) begin
      cyc();
      checks++;
      if ({out_vld, out_vid} !== {1'b1, VW'(15'h21 + i)}) begin
        errs++;
        $display("FAIL b2b %0d got vld=%b vid=%h exp 1 %h", i, out_vld, out_vid, VW'(15'h21 + i));
      end
    end
    cyc();
    checks++;
    if (out_vld !== 1'b0) begin errs++; $display("FAIL b2b_end got vld=%b exp 0", out_vld); end
  endtask
  task automatic test_flush();
    reset_dut();
    out_rdy = 1'b0;
    push_h(15'h31, 1'b1); push_o(15'h0, 1'b0, 1'b0);
    cyc();
    push_h(15'h32, 1'b1); push_o(15'h0, 1'b0, 1'b0);
    cyc(); idle();
    flush = 1'b1;
    cyc(); idle();
    checks++;
    if ({out_vld, out_vid, key_stall} !== {1'b1, 15'h31, 1'b1}) begin
      errs++;
      $display("FAIL flush_hold got vld=%b vid=%h ks=%b exp 1 0031 1", out_vld, out_vid, key_stall);
    end
    push_h(15'h3F, 1'b1); push_o(15'h0, 1'b0, 1'b0);
    cyc(); idle();
    checks++;
    if ({out_vld, out_vid} !== {1'b1, 15'h31}) begin
      errs++;
      $display("FAIL flush_hold2 got vld=%b vid=%h exp 1 0031", out_vld, out_vid);
    end
    out_rdy = 1'b1;
    cyc();
    checks++;
    if ({out_vld, key_stall} !== 2'b01) begin
      errs++;
      $display("FAIL flush_accept got vld=%b ks=%b exp 0 1", out_vld, key_stall);
    end
    cyc();
    checks++;
    if ({out_vld, key_stall} !== 2'b00) begin
      errs++;
      $display("FAIL flush_done got vld=%b ks=%b exp 0 0", out_vld, key_stall);
    end
    push_h(15'h33, 1'b1); push_o(15'h0, 1'b0, 1'b0);
    cyc(); idle();
    checks++;
    if ({out_vld, out_vid} !== {1'b1, 15'h33}) begin
      errs++;
      $display("FAIL flush_empty got vld=%b vid=%h exp 1 0033", out_vld, out_vid);
    end
    cyc();
  endtask
  initial begin
    test_reset();
    test_latency();
    test_resolve();
    test_full();
    test_back_to_back();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
